sw_alloc_vc: RTL and testbench
==============================

Name: sw_alloc_vc

Overview:
Synchronous switch allocator for the 5-port, VCN-VC-per-port router data crossbar. It arbitrates input-VC requests for output ports and drives the one-hot routing guides (srtg/wrtg/nrtg/ertg/lrtg) that steer the crossbar demuxes. Each grant is held for a whole packet and released when that output transfers a tail flit. Port order everywhere: 0=S, 1=W, 2=N, 3=E, 4=L.

Parameters:
VCN, 2, VCs per input direction
NC, 5*VCN, candidate count per output arbiter (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
req  in  [4:0][VCN-1:0]  input VC has a head flit waiting; level, held until granted
reqdir  in  [4:0][VCN-1:0][2:0]  requested output index 0..4; 5..7 illegal
ofire  in  [4:0]  output port completed one flit transfer this cycle
otail  in  [4:0]  flit completed on that output is a tail; qualified by ofire
srtg  out  [VCN-1:0][3:0]  S-input guide; bits 0..3 select outputs W,N,E,L
wrtg  out  [VCN-1:0][1:0]  W-input guide; bits 0..1 select outputs E,L
nrtg  out  [VCN-1:0][3:0]  N-input guide; bits 0..3 select outputs S,W,E,L
ertg  out  [VCN-1:0][1:0]  E-input guide; bits 0..1 select outputs W,L
lrtg  out  [VCN-1:0][3:0]  L-input guide; bits 0..3 select outputs S,W,N,E
obusy  out  [4:0]  output port currently owned
rterr  out  1  one-cycle pulse when an illegal request is present

Behaviour:
- Reset (async): all rtg outputs 0, obusy 0, rterr 0, all output FSMs IDLE, all arbiter pointers 0.
- Legal turns (XY routing):
  - S input -> W, N, E, L
  - W input -> E, L
  - N input -> S, W, E, L
  - E input -> W, L
  - L input -> S, W, N, E
- A request is illegal if it asks for a U-turn, a turn not listed above, or reqdir > 4.
  - Illegal requests are never granted.
  - rterr is registered and is 1 in every cycle after a cycle in which at least one illegal request was present.
- Each output o has a two-state FSM, IDLE and BUSY, with an owner register {dir[2:0], vc}.
- In IDLE:
  - Candidates are the legal requests with reqdir == o from input VCs that hold no grant.
  - Candidate index = dir*VCN + vc.
  - A round-robin arbiter picks the first candidate at or after the pointer, wrapping mod NC.
  - On a win: next cycle state is BUSY, owner is latched, the corresponding rtg bit is 1, obusy[o] is 1, and the pointer becomes (winner+1) mod NC.
- Grant latency: request in cycle t -> guide bit high in cycle t+1.
- In BUSY:
  - When ofire[o] && otail[o]: next cycle the rtg bit is 0, obusy[o] is 0, state is IDLE.
  - The earliest re-grant of o is visible at t+2 after the tail fire at t (one bubble cycle).
  - ofire without otail, or otail without ofire: no state change.
- Invariants:
  - At most one rtg bit per input VC is set.
  - At most one owner per output.
  - Distinct VCs of the same input may own different outputs simultaneously.
- Simultaneous events:
  - Every output arbitrates independently in the same cycle.
  - A release and a new request on the same output in the same cycle: the release wins and the request waits.
- req deasserting while in BUSY has no effect; only the tail releases the output.
- Reset asserted mid-packet: everything clears immediately. The environment must flush the crossbar.

Decomposition:
- Package sw_alloc_pkg holds:
  - direction constants (DIR_S=0 .. DIR_L=4)
  - the turn-legality function legal(in_dir, out_dir)
  - the function mapping (in_dir, out_dir) to the rtg bit index
  - the owner struct typedef
- One sub-module, rr_arb:
  - parameter N
  - inputs: clk, rst, req[N-1:0], en
  - output: one-hot gnt[N-1:0]
  - internal rotating pointer; the pointer advances only when en is high and a grant is issued
- Five rr_arb instances are generated, one per output. Legality and direction filtering are done in the top level.

Test Plan:
1. Reset, then req[0][0]=1 with reqdir=3 (S->E) at t0 -> srtg[0]=4'b0100 and obusy=5'b01000 at t0+1. Then ofire[3]=otail[3]=1 at t5 -> srtg[0]=0 and obusy[3]=0 at t6.
2. Fairness: req[4][0], req[4][1] and req[2][0] all request W (1) and are held. Each packet is one tail flit per grant. -> Grant order is N.vc0, L.vc0, L.vc1, N.vc0 (pointer wrap). Exactly one bubble cycle between grants.
3. Illegal requests: req[1][0] with reqdir=1 (W U-turn) and req[3][1] with reqdir=6 -> no rtg bit and obusy unchanged. rterr=1 in the following cycle.
4. Parallel grants: S.vc0->N and S.vc1->L in the same cycle -> srtg[0]=4'b0010 and srtg[1]=4'b1000 in the same cycle, obusy=5'b10100.
5. Hold: owner of E deasserts req and ofire[3]=1 with otail=0 for 4 cycles -> grant is held. Assert rst mid-packet -> all outputs 0 asynchronously. After release, a new request is granted 1 cycle later.

Source files
------------

// File: rtl/sw_alloc_pkg.sv
// Shared definitions for the switch allocator: port directions, XY turn
// legality, guide bit mapping, owner record and output FSM encodings.
package sw_alloc_pkg;

  localparam int DIR_S = 0;
  localparam int DIR_W = 1;
  localparam int DIR_N = 2;
  localparam int DIR_E = 3;
  localparam int DIR_L = 4;
  localparam int NDIR  = 5;

  // Output FSM states
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  // Input VC holding an output: direction plus VC number (room for 16 VCs)
  typedef struct packed {
    logic [2:0] dir;
    logic [3:0] vc;
  } owner_t;

  // XY routing turn table; any out_dir above 4 is rejected as well
  function automatic logic legal(input int in_dir, input int out_dir);
    case (in_dir)
      DIR_S:   legal = (out_dir == DIR_W) || (out_dir == DIR_N) ||
                       (out_dir == DIR_E) || (out_dir == DIR_L);
      DIR_W:   legal = (out_dir == DIR_E) || (out_dir == DIR_L);
      DIR_N:   legal = (out_dir == DIR_S) || (out_dir == DIR_W) ||
                       (out_dir == DIR_E) || (out_dir == DIR_L);
      DIR_E:   legal = (out_dir == DIR_W) || (out_dir == DIR_L);
      DIR_L:   legal = (out_dir == DIR_S) || (out_dir == DIR_W) ||
                       (out_dir == DIR_N) || (out_dir == DIR_E);
      default: legal = 1'b0;
    endcase
  endfunction

  // Bit position of a legal turn inside the input's compacted guide vector
  function automatic int rtg_idx(input int in_dir, input int out_dir);
    case (in_dir)
      DIR_S:   rtg_idx = out_dir - 1;                               // W,N,E,L
      DIR_W:   rtg_idx = out_dir - 3;                               // E,L
      DIR_N:   rtg_idx = (out_dir < DIR_E) ? out_dir : out_dir - 1; // S,W,E,L
      DIR_E:   rtg_idx = (out_dir == DIR_W) ? 0 : 1;                // W,L
      default: rtg_idx = out_dir;                                   // S,W,N,E
    endcase
  endfunction

endpackage

// File: rtl/sw_alloc_vc_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// wrapping; the pointer moves past the winner only on an enabled grant.
module rr_arb #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_reg, ptr_next;
  logic [N-1:0]  pick;
  logic          found;

  // Search from the pointer upward first, then wrap to the low indices
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr_reg))) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign gnt = en ? pick : '0;

  // Next pointer is one past the winner, modulo N
  always_comb begin
    ptr_next = ptr_reg;
    if (en && found) begin
      for (int i = 0; i < N; i++) begin
        if (pick[i]) ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/sw_alloc_vc.sv
// Switch allocator for the 5-port router crossbar. One IDLE/BUSY owner FSM
// and one round-robin arbiter per output; a grant lasts until that output
// transfers a tail flit. Guides are decoded from the registered owners.
module sw_alloc_vc
  import sw_alloc_pkg::*;
#(
  parameter int VCN = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4:0][VCN-1:0]           req,
  input  logic [4:0][VCN-1:0][2:0]      reqdir,
  input  logic [4:0]                    ofire,
  input  logic [4:0]                    otail,
  output logic [VCN-1:0][3:0]           srtg,
  output logic [VCN-1:0][1:0]           wrtg,
  output logic [VCN-1:0][3:0]           nrtg,
  output logic [VCN-1:0][1:0]           ertg,
  output logic [VCN-1:0][3:0]           lrtg,
  output logic [4:0]                    obusy,
  output logic                          rterr
);

  localparam int NC = NDIR * VCN;

  logic [4:0]          state_reg, state_next;
  owner_t [4:0]        owner_reg, owner_next;
  logic [4:0][VCN-1:0] held;
  logic [4:0][NC-1:0]  cand;
  logic [4:0][NC-1:0]  gnt;
  logic                illegal_any;
  logic                rterr_reg;

  // An input VC that already owns some output may not compete again
  always_comb begin
    held = '0;
    for (int d = 0; d < NDIR; d++) begin
      for (int v = 0; v < VCN; v++) begin
        for (int o = 0; o < NDIR; o++) begin
          if ((state_reg[o] == ST_BUSY) && (owner_reg[o].dir == 3'(d)) &&
              (owner_reg[o].vc == 4'(v)))
            held[d][v] = 1'b1;
        end
      end
    end
  end

  // Sort requests into per-output candidate vectors and flag illegal turns
  always_comb begin
    cand        = '0;
    illegal_any = 1'b0;
    for (int d = 0; d < NDIR; d++) begin
      for (int v = 0; v < VCN; v++) begin
        if (req[d][v] && !legal(d, int'(reqdir[d][v])))
          illegal_any = 1'b1;
        for (int o = 0; o < NDIR; o++) begin
          if (req[d][v] && !held[d][v] && (reqdir[d][v] == 3'(o)) && legal(d, o))
            cand[o][d*VCN + v] = 1'b1;
        end
      end
    end
  end

  // Arbitration only runs while the output is idle, so a release cycle
  // always leaves a bubble before the next owner is chosen
  for (genvar gi = 0; gi < NDIR; gi++) begin : g_arb
    rr_arb #(.N(NC)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (cand[gi]),
      .en  (state_reg[gi] == ST_IDLE),
      .gnt (gnt[gi])
    );
  end

  // Per-output FSM: latch the winner in IDLE, drop ownership on a tail fire
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    for (int o = 0; o < NDIR; o++) begin
      case (state_reg[o])
        ST_IDLE: begin
          if (|gnt[o]) begin
            state_next[o] = ST_BUSY;
            for (int i = 0; i < NC; i++) begin
              if (gnt[o][i]) begin
                owner_next[o].dir = 3'(i / VCN);
                owner_next[o].vc  = 4'(i % VCN);
              end
            end
          end
        end
        default: begin
          if (ofire[o] && otail[o]) state_next[o] = ST_IDLE;
        end
      endcase
    end
  end

  // State, owner and error flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= {NDIR{ST_IDLE}};
      owner_reg <= '0;
      rterr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      rterr_reg <= illegal_any;
    end
  end

  assign obusy = state_reg;
  assign rterr = rterr_reg;

  // Guide decode: only legal turns get a bit, so every guide bit has one driver
  for (genvar gi = 0; gi < NDIR; gi++) begin : g_in
    for (genvar gv = 0; gv < VCN; gv++) begin : g_vc
      for (genvar go = 0; go < NDIR; go++) begin : g_out
        if (legal(gi, go)) begin : g_turn
          localparam int BIT = rtg_idx(gi, go);
          logic hit;
          assign hit = (state_reg[go] == ST_BUSY) && (owner_reg[go].dir == 3'(gi)) &&
                       (owner_reg[go].vc == 4'(gv));
          if (gi == DIR_S) begin : g_s
            assign srtg[gv][BIT] = hit;
          end else if (gi == DIR_W) begin : g_w
            assign wrtg[gv][BIT] = hit;
          end else if (gi == DIR_N) begin : g_n
            assign nrtg[gv][BIT] = hit;
          end else if (gi == DIR_E) begin : g_e
            assign ertg[gv][BIT] = hit;
          end else begin : g_l
            assign lrtg[gv][BIT] = hit;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_alloc_vc.sv
// Self-checking bench for sw_alloc_vc: every stimulus step pushes the
// expected guide/busy/error snapshot, which is popped and compared after
// the following clock edge.
module tb_sw_alloc_vc;

  localparam int VCN = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [4:0][VCN-1:0]      req;
  logic [4:0][VCN-1:0][2:0] reqdir;
  logic [4:0]               ofire;
  logic [4:0]               otail;
  logic [VCN-1:0][3:0]      srtg;
  logic [VCN-1:0][1:0]      wrtg;
  logic [VCN-1:0][3:0]      nrtg;
  logic [VCN-1:0][1:0]      ertg;
  logic [VCN-1:0][3:0]      lrtg;
  logic [4:0]               obusy;
  logic                     rterr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] s;
    logic [3:0] w;
    logic [7:0] n;
    logic [3:0] e;
    logic [7:0] l;
    logic [4:0] ob;
    logic       er;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  sw_alloc_vc #(.VCN(VCN)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .reqdir (reqdir),
    .ofire  (ofire),
    .otail  (otail),
    .srtg   (srtg),
    .wrtg   (wrtg),
    .nrtg   (nrtg),
    .ertg   (ertg),
    .lrtg   (lrtg),
    .obusy  (obusy),
    .rterr  (rterr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] s, input logic [3:0] w,
                          input logic [7:0] n, input logic [3:0] e, input logic [7:0] l,
                          input logic [4:0] ob, input logic er);
    exp_t x;
    x.tag = tag; x.s = s; x.w = w; x.n = n; x.e = e; x.l = l; x.ob = ob; x.er = er;
    exp_q.push_back(x);
  endtask

  task automatic pop_cmp();
    exp_t x;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    x = exp_q.pop_front();
    chk({x.tag, ".srtg"},  32'(srtg),  32'(x.s));
    chk({x.tag, ".wrtg"},  32'(wrtg),  32'(x.w));
    chk({x.tag, ".nrtg"},  32'(nrtg),  32'(x.n));
    chk({x.tag, ".ertg"},  32'(ertg),  32'(x.e));
    chk({x.tag, ".lrtg"},  32'(lrtg),  32'(x.l));
    chk({x.tag, ".obusy"}, 32'(obusy), 32'(x.ob));
    chk({x.tag, ".rterr"}, 32'(rterr), 32'(x.er));
    $display("txn %-16s srtg=%h wrtg=%h nrtg=%h ertg=%h lrtg=%h obusy=%b rterr=%b",
             x.tag, srtg, wrtg, nrtg, ertg, lrtg, obusy, rterr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock step: expectation for the next edge is queued with the stimulus
  task automatic cyc(input string tag, input logic [7:0] s, input logic [3:0] w,
                     input logic [7:0] n, input logic [3:0] e, input logic [7:0] l,
                     input logic [4:0] ob, input logic er);
    push_exp(tag, s, w, n, e, l, ob, er);
    tick();
    pop_cmp();
  endtask

  task automatic tail_on(input int o);
    ofire[o] = 1'b1;
    otail[o] = 1'b1;
  endtask

  task automatic clear_fire();
    ofire = '0;
    otail = '0;
  endtask

  initial begin
    req    = '0;
    reqdir = '0;
    clear_fire();

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp("reset", 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 5'b00000, 1'b0);
    pop_cmp();

    // 1: S.vc0 -> E, hold, then tail release
    req[0][0] = 1'b1; reqdir[0][0] = 3'd3;
    cyc("t1_grant", 8'h04, 4'h0, 8'h00, 4'h0, 8'h00, 5'b01000, 1'b0);
    req[0][0] = 1'b0;
    for (int k = 0; k < 4; k++)
      cyc("t1_hold", 8'h04, 4'h0, 8'h00, 4'h0, 8'h00, 5'b01000, 1'b0);
    tail_on(3);
    cyc("t1_release", 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 5'b00000, 1'b0);
    clear_fire();

    // 2: fairness on output W among N.vc0 (idx 4), L.vc0 (8), L.vc1 (9)
    req[4][0] = 1'b1; reqdir[4][0] = 3'd1;
    req[4][1] = 1'b1; reqdir[4][1] = 3'd1;
    req[2][0] = 1'b1; reqdir[2][0] = 3'd1;
    cyc("t2_g_n0", 8'h00, 4'h0, 8'h02, 4'h0, 8'h00, 5'b00010, 1'b0);
    tail_on(1);
    cyc("t2_bubble1", 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 5'b00000, 1'b0);
    clear_fire();
    cyc("t2_g_l0", 8'h00, 4'h0, 8'h00, 4'h0, 8'h02, 5'b00010, 1'b0);
    tail_on(1);
    cyc("t2_bubble2", 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 5'b00000, 1'b0);
    clear_fire();
    cyc("t2_g_l1", 8'h00, 4'h0, 8'h00, 4'h0, 8'h20, 5'b00010, 1'b0);
    tail_on(1);
    cyc("t2_bubble3", 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 5'b00000, 1'b0);
    clear_fire();
    cyc("t2_g_n0_wrap", 8'h00, 4'h0, 8'h02, 4'h0, 8'h00, 5'b00010, 1'b0);
    tail_on(1);
    req = '0;
    cyc("t2_end", 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 5'b00000, 1'b0);
    clear_fire();

    // 3: illegal requests (W U-turn, E reqdir=6)
    req[1][0] = 1'b1; reqdir[1][0] = 3'd1;
    req[3][1] = 1'b1; reqdir[3][1] = 3'd6;
    cyc("t3_illegal", 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 5'b00000, 1'b1);
    cyc("t3_illegal2", 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 5'b00000, 1'b1);
    req = '0;
    cyc("t3_clear", 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 5'b00000, 1'b0);

    // 4: parallel grants S.vc0 -> N and S.vc1 -> L
    req[0][0] = 1'b1; reqdir[0][0] = 3'd2;
    req[0][1] = 1'b1; reqdir[0][1] = 3'd4;
    cyc("t4_parallel", 8'h82, 4'h0, 8'h00, 4'h0, 8'h00, 5'b10100, 1'b0);
    req = '0;
    tail_on(2);
    tail_on(4);
    cyc("t4_release", 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 5'b00000, 1'b0);
    clear_fire();

    // 5: L.vc1 owns E; non-tail fires and a lone otail must not release it
    req[4][1] = 1'b1; reqdir[4][1] = 3'd3;
    cyc("t5_grant", 8'h00, 4'h0, 8'h00, 4'h0, 8'h80, 5'b01000, 1'b0);
    req = '0;
    ofire[3] = 1'b1;
    for (int k = 0; k < 4; k++)
      cyc("t5_hold", 8'h00, 4'h0, 8'h00, 4'h0, 8'h80, 5'b01000, 1'b0);
    ofire[3] = 1'b0;
    otail[3] = 1'b1;
    cyc("t5_tail_only", 8'h00, 4'h0, 8'h00, 4'h0, 8'h80, 5'b01000, 1'b0);
    clear_fire();

    // Asynchronous reset mid-packet clears without a clock edge
    rst = 1'b1;
    #1;
    push_exp("t5_async_rst", 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 5'b00000, 1'b0);
    pop_cmp();
    req[1][0] = 1'b1; reqdir[1][0] = 3'd3;
    tick();
    rst = 1'b0;
    cyc("t5_regrant", 8'h00, 4'h1, 8'h00, 4'h0, 8'h00, 5'b01000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
